// File: rtl/uart_tx_fifo_if.sv
// Bus-side handshake bundle for uart_tx_fifo: write data and strobes in,
// serial line and status flags out.
interface uart_tx_fifo_if;
  logic [15:0] d;
  logic        wrtx;
  logic        wrbaud;
  logic        txd;
  logic        thre;
  logic        busy;

  modport master (
    output d, wrtx, wrbaud,
    input  txd, thre, busy
  );

  modport slave (
    input  d, wrtx, wrbaud,
    output txd, thre, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// CPU pushes bytes into a DEPTH-entry FIFO; a baud down-counter and FSM
// serialise them LSB first on txd, back-to-back while data remains.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after D7.
module uart_tx_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] BAUD_RST = 16'd7
) (
  input logic          clk,
  input logic          resetb,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [15:0] div_q;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        txd_q, txd_d;
  logic        empty, full, push, pop, tick;
  logic [7:0]  head;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = bus.wrtx & ~full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign tick  = (cnt_q == '0);

  assign bus.txd  = txd_q;
  assign bus.thre = ~full;
  assign bus.busy = (state_q != IDLE) | ~empty;

  // Next-state, baud counter, shifter and the txd value driven next cycle.
  // txd is derived from the current state so it lags the FSM by one cycle;
  // every bit keeps its full length on the line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = div_q;
          state_d = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (tick) begin
          cnt_d   = div_q;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (tick) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_d = par_q;
        if (tick) begin
          cnt_d   = div_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        txd_d = 1'b1;
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            cnt_d   = div_q;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointers, divider and registered serial output.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      div_q    <= BAUD_RST;
      cnt_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (bus.wrbaud) div_q <= bus.d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte being loaded, captured at pop time.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      par_q <= 1'b0;
    end else if (pop) begin
      par_q <= ^head;
    end
  end
`endif

  // FIFO storage; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.d[7:0];
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic resetb = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.DEPTH(4), .BAUD_RST(16'd7)) dut (
    .clk   (clk),
    .resetb(resetb),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line history and transition log, sampled mid-cycle.
  logic txd_hist  [4096];
  logic busy_hist [4096];
  int   log_t [$];
  logic log_v [$];
  logic prev_txd = 1'b1;

  always @(negedge clk) begin
    if (bus.txd !== prev_txd) begin
      log_t.push_back(cyc);
      log_v.push_back(bus.txd);
      prev_txd = bus.txd;
    end
    if (cyc < 4096) begin
      txd_hist[cyc]  = bus.txd;
      busy_hist[cyc] = bus.busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic set_div(input logic [15:0] v);
    @(negedge clk);
    bus.d = v; bus.wrbaud = 1'b1;
    @(negedge clk);
    bus.wrbaud = 1'b0;
  endtask

  task automatic test_reset;
    bus.d = '0; bus.wrtx = 1'b0; bus.wrbaud = 1'b0;
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b expected 1", bus.txd); end
    total++; if (bus.thre !== 1'b1) begin bad++; $display("FAIL reset_thre: got %b expected 1", bus.thre); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    resetb = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Reset divider (7): 0x41 -> 0,1,0,0,0,0,0,1,0,[p=0],1 at 8 cycles/bit.
  task automatic test_single;
    int base, n0, t0;
`ifdef UART_TX_PARITY_EN
    int off[6] = '{0, 8, 16, 56, 64, 80};
`else
    int off[6] = '{0, 8, 16, 56, 64, 72};
`endif
    logic val[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    base = log_t.size();
    @(negedge clk);
    bus.d = 16'h0041; bus.wrtx = 1'b1; n0 = cyc + 1;
    @(negedge clk);
    bus.wrtx = 1'b0;
    t0 = n0 + 2;
    wait_cyc(t0 + FB*8 + 10);
    total++;
    if (log_t.size() - base != 6) begin
      bad++; $display("FAIL single_count: got %0d expected 6", log_t.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (log_t[base+i] !== t0 + off[i] || log_v[base+i] !== val[i]) begin
          bad++; $display("FAIL single_edge%0d: got t=%0d v=%b expected t=%0d v=%b",
                          i, log_t[base+i] - t0, log_v[base+i], off[i], val[i]);
        end
      end
    end
    total++; if (busy_hist[t0 + FB*8 - 2] !== 1'b1) begin bad++; $display("FAIL single_busy_hi: got %b expected 1", busy_hist[t0 + FB*8 - 2]); end
    total++; if (busy_hist[t0 + FB*8] !== 1'b0) begin bad++; $display("FAIL single_busy_lo: got %b expected 0", busy_hist[t0 + FB*8]); end
  endtask

  // 0x41 then 0x43 two cycles later: second start exactly one frame later.
  task automatic test_back_to_back;
    int base, n0, t0;
`ifdef UART_TX_PARITY_EN
    int off[12] = '{0, 8, 16, 56, 64, 80, 88, 96, 112, 144, 152, 160};
`else
    int off[12] = '{0, 8, 16, 56, 64, 72, 80, 88, 104, 136, 144, 152};
`endif
    base = log_t.size();
    @(negedge clk);
    bus.d = 16'h0041; bus.wrtx = 1'b1; n0 = cyc + 1;
    @(negedge clk);
    bus.wrtx = 1'b0;
    @(negedge clk);
    bus.d = 16'h0043; bus.wrtx = 1'b1;
    @(negedge clk);
    bus.wrtx = 1'b0;
    t0 = n0 + 2;
    wait_cyc(t0 + 2*FB*8 + 10);
    total++;
    if (log_t.size() - base != 12) begin
      bad++; $display("FAIL b2b_count: got %0d expected 12", log_t.size() - base);
    end else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (log_t[base+i] !== t0 + off[i] || log_v[base+i] !== logic'(i % 2)) begin
          bad++; $display("FAIL b2b_edge%0d: got t=%0d v=%b expected t=%0d v=%0d",
                          i, log_t[base+i] - t0, log_v[base+i], off[i], i % 2);
        end
      end
    end
    total++; if (busy_hist[t0 + 2*FB*8] !== 1'b0) begin bad++; $display("FAIL b2b_busy_lo: got %b expected 0", busy_hist[t0 + 2*FB*8]); end
  endtask

  // Divider 0, six writes in consecutive cycles: five frames, sixth dropped.
  task automatic test_fifo_full;
    int n0, t0, zeros;
    logic [7:0] bytes[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [FB-1:0] obs, expv;
    set_div(16'd0);
    @(negedge clk);
    n0 = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        total++; if (bus.thre !== 1'b1) begin bad++; $display("FAIL full_thre3: got %b expected 1", bus.thre); end
      end
      if (i == 5) begin
        total++; if (bus.thre !== 1'b0) begin bad++; $display("FAIL full_thre4: got %b expected 0", bus.thre); end
      end
      bus.d = {8'h00, bytes[i]}; bus.wrtx = 1'b1;
      @(negedge clk);
    end
    bus.wrtx = 1'b0;
    t0 = n0 + 2;
    wait_cyc(t0 + 5*FB + 25);
    for (int f = 0; f < 5; f++) begin
      for (int j = 0; j < FB; j++) obs[j] = txd_hist[t0 + f*FB + j];
`ifdef UART_TX_PARITY_EN
      expv = {1'b1, ^bytes[f], bytes[f], 1'b0};
`else
      expv = {1'b1, bytes[f], 1'b0};
`endif
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL full_frame%0d: got %b expected %b", f, obs, expv);
      end
    end
    zeros = 0;
    for (int j = 0; j < 20; j++) if (txd_hist[t0 + 5*FB + j] !== 1'b1) zeros++;
    total++; if (zeros != 0) begin bad++; $display("FAIL full_drop: got %0d low cycles expected 0", zeros); end
    total++; if (busy_hist[t0 + 5*FB + 1] !== 1'b0) begin bad++; $display("FAIL full_busy: got %b expected 0", busy_hist[t0 + 5*FB + 1]); end
    set_div(16'd7);
  endtask

  // wrbaud=3 during D2 of 0x55 at divider 7: D2 stays 8, D3 onward 4.
  task automatic test_baud_change;
    int base, n0, t0;
`ifdef UART_TX_PARITY_EN
    int off[10] = '{0, 8, 16, 24, 32, 36, 40, 44, 48, 56};
`else
    int off[10] = '{0, 8, 16, 24, 32, 36, 40, 44, 48, 52};
`endif
    base = log_t.size();
    @(negedge clk);
    bus.d = 16'h0055; bus.wrtx = 1'b1; n0 = cyc + 1;
    @(negedge clk);
    bus.wrtx = 1'b0;
    t0 = n0 + 2;
    wait_cyc(t0 + 25);
    bus.d = 16'd3; bus.wrbaud = 1'b1;
    @(negedge clk);
    bus.wrbaud = 1'b0;
    wait_cyc(t0 + 80);
    total++;
    if (log_t.size() - base != 10) begin
      bad++; $display("FAIL baud_count: got %0d expected 10", log_t.size() - base);
    end else begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (log_t[base+i] !== t0 + off[i] || log_v[base+i] !== logic'(i % 2)) begin
          bad++; $display("FAIL baud_edge%0d: got t=%0d v=%b expected t=%0d v=%0d",
                          i, log_t[base+i] - t0, log_v[base+i], off[i], i % 2);
        end
      end
    end
    set_div(16'd7);
  endtask

  // Reset during D4 of 0x41 with 0x43 queued: line returns high, nothing more sent.
  task automatic test_reset_midframe;
    int base, n0, t0;
    int off[4] = '{0, 8, 16, 42};
    base = log_t.size();
    @(negedge clk);
    bus.d = 16'h0041; bus.wrtx = 1'b1; n0 = cyc + 1;
    @(negedge clk);
    bus.d = 16'h0043;
    @(negedge clk);
    bus.wrtx = 1'b0;
    t0 = n0 + 2;
    wait_cyc(t0 + 41);
    resetb = 1'b0;
    @(negedge clk);
    total++; if (bus.txd !== 1'b1) begin bad++; $display("FAIL rst_txd: got %b expected 1", bus.txd); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    total++; if (bus.thre !== 1'b1) begin bad++; $display("FAIL rst_thre: got %b expected 1", bus.thre); end
    resetb = 1'b1;
    wait_cyc(t0 + 250);
    total++;
    if (log_t.size() - base != 4) begin
      bad++; $display("FAIL rst_count: got %0d expected 4", log_t.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (log_t[base+i] !== t0 + off[i] || log_v[base+i] !== logic'(i % 2)) begin
          bad++; $display("FAIL rst_edge%0d: got t=%0d v=%b expected t=%0d v=%0d",
                          i, log_t[base+i] - t0, log_v[base+i], off[i], i % 2);
        end
      end
    end
  endtask

  // wrtx and wrbaud together with d=0x0003: byte 0x03 sent at 4 cycles/bit.
  task automatic test_same_cycle;
    int base, n0, t0;
`ifdef UART_TX_PARITY_EN
    int off[4] = '{0, 4, 12, 40};
`else
    int off[4] = '{0, 4, 12, 36};
`endif
    base = log_t.size();
    @(negedge clk);
    bus.d = 16'h0003; bus.wrtx = 1'b1; bus.wrbaud = 1'b1; n0 = cyc + 1;
    @(negedge clk);
    bus.wrtx = 1'b0; bus.wrbaud = 1'b0;
    t0 = n0 + 2;
    wait_cyc(t0 + 60);
    total++;
    if (log_t.size() - base != 4) begin
      bad++; $display("FAIL same_count: got %0d expected 4", log_t.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (log_t[base+i] !== t0 + off[i] || log_v[base+i] !== logic'(i % 2)) begin
          bad++; $display("FAIL same_edge%0d: got t=%0d v=%b expected t=%0d v=%0d",
                          i, log_t[base+i] - t0, log_v[base+i], off[i], i % 2);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_fifo_full;
    test_baud_change;
    test_reset_midframe;
    test_same_cycle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
